bus_interconnect: RTL and testbench
===================================

// Module: bus_interconnect
// PURPOSE
//  Single-cycle N-host to M-device memory interconnect for the simple system.
//  Arbitrates host requests with fixed priority and decodes the address
//  against per-device base/mask windows. Forwards one request per cycle to
//  one device and routes that device's response back to the issuing host.
//  Sits between the core data port and RAM / sim-ctrl / timer.
// PARAMETERS
//  NrDevices     3   number of device (slave) ports, >=1
//  NrHosts       1   number of host (master) ports, >=1
//  DataWidth     32  data bus width; byte-enable width = DataWidth/8
//  AddressWidth  32  address width
// PORTS
//  clk_i                 in   1            system clock
//  rst_ni                in   1            async reset, active low
//  host_req_i[NrHosts]   in   1            host request
//  host_gnt_o[NrHosts]   out  1            request accepted this cycle
//  host_addr_i[NrHosts]  in   AW           byte address
//  host_we_i[NrHosts]    in   1            1=write, 0=read
//  host_be_i[NrHosts]    in   DW/8         byte enables
//  host_wdata_i[NrHosts] in   DW           write data
//  host_rvalid_o[NrHosts] out 1            response valid
//  host_rdata_o[NrHosts] out  DW           read data
//  host_err_o[NrHosts]   out  1            response error
//  device_req_o[NrDevices]   out 1         one-hot device request
//  device_addr_o/we_o/be_o/wdata_o[NrDevices] out AW/1/DW/8/DW  forwarded fields
//  device_rvalid_i/rdata_i/err_i[NrDevices]   in 1/DW/1         device response
//  cfg_device_addr_base[NrDevices] in AW   window base
//  cfg_device_addr_mask[NrDevices] in AW   window mask (~(size-1))
// BEHAVIOUR
//  - Arbitration: lowest-index host with req=1 wins. host_gnt_o is 1 only for
//    the winner, combinationally in the same cycle. Other hosts see gnt=0 and
//    hold their request.
//  - Decode: device i matches when (addr & mask[i]) == base[i]. The
//    lowest-index match wins. Match is computed on the winning host's address.
//  - device_req_o[sel]=1 for the decoded device only. addr/we/be/wdata of the
//    winner are broadcast to every device port. All-zero when there is no
//    winner.
//  - Unmapped address: the request is still granted and no device_req is
//    raised. Next cycle the host gets rvalid=1, err=1, rdata=0.
//  - Response: devices answer exactly one cycle after req. A registered
//    (host_sel, dev_sel, unmapped, valid) tuple steers device_rvalid/rdata/err
//    of dev_sel to host_sel. All other hosts get rvalid=0, rdata=0, err=0.
//  - Back-to-back: a new grant every cycle is allowed (one outstanding
//    transaction per cycle, pipelined). A response and a new request may
//    coincide.
//  - Reset (async, rst_ni=0): steering regs cleared, valid=0. All
//    host_rvalid_o=0, host_err_o=0, host_rdata_o=0. gnt/device_req follow
//    inputs combinationally, but are gated to 0 while in reset.
//  - Reset mid-transaction: the pending response is dropped and no rvalid is
//    issued after release.
//  - Writes produce an rvalid response like reads. rdata is passed through
//    from the device unchanged.
// STRUCTURE
//  - Flat module. Arbiter and decoder are generate loops.
//  - Optional sub-module bus_addr_decode (one-hot + index) shared with the
//    unmapped detection.
//  - Package bus_pkg: typedefs host_idx_t/dev_idx_t (clog2-sized) and
//    RESP_LATENCY=1.
// TESTING
//  1 Host0 read 0x0010_0040 (RAM base 0x100000, mask ~0xFFFFF) -> gnt same
//    cycle; device_req[0]=1; next cycle rvalid=1, rdata=RAM value.
//  2 Write 0x0002_0008 wdata=0x41 be=0001 -> device_req[1] (SimCtrl) only;
//    rvalid next cycle, err=0.
//  3 Read 0x0003_0000 with timer err_i=1 -> host_err_o=1 on the response cycle.
//  4 Read unmapped 0x0000_0004 -> gnt=1, no device_req; next cycle rvalid=1,
//    err=1, rdata=0.
//  5 NrHosts=2, both req -> host0 granted; host1 granted the following cycle;
//    each rvalid goes only to its owner.
//  6 Assert rst_ni=0 while a response is pending -> rvalid stays 0 and all
//    outputs are 0 until release.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the host/device memory interconnect.
// Index types are sized for the largest supported port counts.
package bus_pkg;

  localparam int unsigned MaxHosts     = 16;
  localparam int unsigned MaxDevices   = 16;
  localparam int unsigned HostIdxWidth = $clog2(MaxHosts);
  localparam int unsigned DevIdxWidth  = $clog2(MaxDevices);

  // Cycles between a device request and its response.
  localparam int unsigned RESP_LATENCY = 1;

  typedef logic [HostIdxWidth-1:0] host_idx_t;
  typedef logic [DevIdxWidth-1:0]  dev_idx_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Address window decoder: one-hot select, binary index and hit flag.
// Lowest-index matching window takes priority over any later overlap.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 3,
  parameter int unsigned AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] base   [NrDevices],
  input  logic [AddressWidth-1:0] mask   [NrDevices],
  output logic [NrDevices-1:0]    onehot,
  output dev_idx_t                idx,
  output logic                    hit
);

  logic [NrDevices-1:0] match;

  for (genvar i = 0; i < NrDevices; i++) begin : g_match
    assign match[i] = ((addr & mask[i]) == base[i]);
  end

  always_comb begin
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < NrDevices; i++) begin
      if (match[i] && !hit) begin
        onehot[i] = 1'b1;
        idx       = dev_idx_t'(i);
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-cycle N-host to M-device interconnect: fixed-priority arbitration,
// base/mask address decode and one-cycle registered response steering.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 3,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      host_req_i           [NrHosts],
  output logic                      host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
  input  logic                      host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
  output logic                      host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
  output logic                      host_err_o           [NrHosts],

  output logic                      device_req_o         [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
  output logic                      device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
  input  logic                      device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
  input  logic                      device_err_i         [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned BeWidth = DataWidth / 8;

  if (NrHosts < 1 || NrHosts > MaxHosts) begin : g_bad_hosts
    $error("NrHosts out of supported range");
  end
  if (NrDevices < 1 || NrDevices > MaxDevices) begin : g_bad_devices
    $error("NrDevices out of supported range");
  end

  // Arbitration: lowest-index requester wins; everything gated low in reset.
  logic [NrHosts-1:0]      gnt;
  logic                    win_valid;
  host_idx_t               win_host;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeWidth-1:0]      win_be;
  logic [DataWidth-1:0]    win_wdata;

  always_comb begin
    gnt       = '0;
    win_valid = 1'b0;
    win_host  = '0;
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (host_req_i[h] && !win_valid && rst_ni) begin
        gnt[h]    = 1'b1;
        win_valid = 1'b1;
        win_host  = host_idx_t'(h);
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  for (genvar h = 0; h < NrHosts; h++) begin : g_gnt
    assign host_gnt_o[h] = gnt[h];
  end

  logic [NrDevices-1:0] dev_onehot;
  dev_idx_t             dev_idx;
  logic                 dev_hit;

  bus_addr_decode #(
    .NrDevices    (NrDevices),
    .AddressWidth (AddressWidth)
  ) u_addr_decode (
    .addr   (win_addr),
    .base   (cfg_device_addr_base),
    .mask   (cfg_device_addr_mask),
    .onehot (dev_onehot),
    .idx    (dev_idx),
    .hit    (dev_hit)
  );

  // Winner fields are already zero when nobody is granted.
  for (genvar d = 0; d < NrDevices; d++) begin : g_dev_out
    assign device_req_o[d]   = win_valid & dev_onehot[d];
    assign device_addr_o[d]  = win_addr;
    assign device_we_o[d]    = win_we;
    assign device_be_o[d]    = win_be;
    assign device_wdata_o[d] = win_wdata;
  end

  // Response steering tuple, captured on every grant.
  logic      rsp_valid_d, rsp_valid_q;
  host_idx_t rsp_host_d, rsp_host_q;
  dev_idx_t  rsp_dev_d, rsp_dev_q;
  logic      rsp_unmapped_d, rsp_unmapped_q;

  always_comb begin
    rsp_valid_d    = win_valid;
    rsp_host_d     = win_host;
    rsp_dev_d      = dev_idx;
    rsp_unmapped_d = ~dev_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q    <= 1'b0;
      rsp_host_q     <= '0;
      rsp_dev_q      <= '0;
      rsp_unmapped_q <= 1'b0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_host_q     <= rsp_host_d;
      rsp_dev_q      <= rsp_dev_d;
      rsp_unmapped_q <= rsp_unmapped_d;
    end
  end

  logic                 sel_rvalid;
  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_err;

  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    sel_err    = 1'b0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (rsp_dev_q == dev_idx_t'(d)) begin
        sel_rvalid = device_rvalid_i[d];
        sel_rdata  = device_rdata_i[d];
        sel_err    = device_err_i[d];
      end
    end
    // Unmapped accesses are answered locally with an error.
    if (rsp_unmapped_q) begin
      sel_rvalid = 1'b1;
      sel_rdata  = '0;
      sel_err    = 1'b1;
    end
  end

  for (genvar h = 0; h < NrHosts; h++) begin : g_host_rsp
    logic owner;
    assign owner            = rsp_valid_q && (rsp_host_q == host_idx_t'(h));
    assign host_rvalid_o[h] = owner & sel_rvalid;
    assign host_rdata_o[h]  = owner ? sel_rdata : '0;
    assign host_err_o[h]    = owner & sel_err;
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomized scoreboard bench for bus_interconnect with two hosts and three
// devices (RAM, SimCtrl, Timer) modelled behaviourally.
module tb_bus_interconnect;
  import bus_pkg::*;

  localparam int NH = 2;
  localparam int ND = 3;

  logic        clk;
  logic        rst_ni;
  logic        host_req    [NH];
  logic        host_gnt    [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid [NH];
  logic [31:0] host_rdata  [NH];
  logic        host_err    [NH];
  logic        dev_req     [ND];
  logic [31:0] dev_addr    [ND];
  logic        dev_we      [ND];
  logic [3:0]  dev_be      [ND];
  logic [31:0] dev_wdata   [ND];
  logic        dev_rvalid  [ND];
  logic [31:0] dev_rdata   [ND];
  logic        dev_err     [ND];
  logic [31:0] cfg_base    [ND];
  logic [31:0] cfg_mask    [ND];

  logic        err_sel     [ND];
  logic        gnt_seen    [NH];

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  exp_t   exp_q[$];
  longint cycle;
  int     tests;
  int     failures;

  bus_interconnect #(
    .NrDevices    (ND),
    .NrHosts      (NH),
    .DataWidth    (32),
    .AddressWidth (32)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .host_req_i           (host_req),
    .host_gnt_o           (host_gnt),
    .host_addr_i          (host_addr),
    .host_we_i            (host_we),
    .host_be_i            (host_be),
    .host_wdata_i         (host_wdata),
    .host_rvalid_o        (host_rvalid),
    .host_rdata_o         (host_rdata),
    .host_err_o           (host_err),
    .device_req_o         (dev_req),
    .device_addr_o        (dev_addr),
    .device_we_o          (dev_we),
    .device_be_o          (dev_be),
    .device_wdata_o       (dev_wdata),
    .device_rvalid_i      (dev_rvalid),
    .device_rdata_i       (dev_rdata),
    .device_err_i         (dev_err),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle++;

  function automatic logic [31:0] salt(input int d);
    return 32'hA5C3_0000 ^ (32'(d + 1) * 32'h0101_0101);
  endfunction

  // First window (lowest index) containing the address, or -1.
  function automatic int exp_dev(input logic [31:0] a);
    for (int d = 0; d < ND; d++) begin
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Device models: answer one cycle after their request; rdata is noise otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] <= dev_req[d];
      dev_err[d]    <= dev_req[d] & err_sel[d];
      dev_rdata[d]  <= dev_req[d] ? (dev_addr[d] ^ salt(d)) : 32'($urandom);
    end
  end

  // Request-side checker: predicts grant/decode and pushes expected responses.
  int           w;
  int           ed;
  logic [NH-1:0] act_gnt, exp_gnt;
  logic [ND-1:0] act_req, exp_req;
  exp_t         e_new;

  always @(negedge clk) begin
    w = -1;
    if (rst_ni === 1'b1) begin
      for (int h = 0; h < NH; h++) if (host_req[h] && w < 0) w = h;
    end
    act_gnt = '0;
    exp_gnt = '0;
    for (int h = 0; h < NH; h++) begin
      act_gnt[h]  = host_gnt[h];
      exp_gnt[h]  = (h == w);
      gnt_seen[h] = host_gnt[h];
    end
    check("gnt", 64'(act_gnt), 64'(exp_gnt));
    ed = (w >= 0) ? exp_dev(host_addr[w]) : -1;
    act_req = '0;
    exp_req = '0;
    for (int d = 0; d < ND; d++) begin
      act_req[d] = dev_req[d];
      exp_req[d] = (w >= 0) && (d == ed);
    end
    check("device_req", 64'(act_req), 64'(exp_req));
    for (int d = 0; d < ND; d++) begin
      if (w >= 0) begin
        check($sformatf("dev%0d_addr", d), 64'(dev_addr[d]), 64'(host_addr[w]));
        check($sformatf("dev%0d_ctl", d), 64'({dev_we[d], dev_be[d], dev_wdata[d]}),
              64'({host_we[w], host_be[w], host_wdata[w]}));
      end else begin
        check($sformatf("dev%0d_idle", d),
              64'({dev_addr[d], dev_we[d], dev_be[d], dev_wdata[d]} != 69'd0), 64'd0);
      end
    end
    if (w >= 0) begin
      e_new.host = w;
      e_new.due  = cycle + longint'(RESP_LATENCY);
      if (ed < 0) begin
        e_new.rdata = 32'h0;
        e_new.err   = 1'b1;
      end else begin
        e_new.rdata = host_addr[w] ^ salt(ed);
        e_new.err   = err_sel[ed];
      end
      exp_q.push_back(e_new);
    end
  end

  // Response monitor: the due response goes only to its owner, others stay zero.
  int   tgt;
  exp_t e_cur;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cycle) begin
      e_cur = exp_q.pop_front();
      check("stale_rsp", 64'(e_cur.due), 64'(cycle));
    end
    tgt = -1;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      e_cur = exp_q.pop_front();
      tgt   = e_cur.host;
    end
    for (int h = 0; h < NH; h++) begin
      if (h == tgt) begin
        check($sformatf("rsp_h%0d", h), 64'({host_rvalid[h], host_err[h], host_rdata[h]}),
              64'({1'b1, e_cur.err, e_cur.rdata}));
      end else begin
        check($sformatf("quiet_h%0d", h), 64'({host_rvalid[h], host_err[h], host_rdata[h]}),
              64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int h = 0; h < NH; h++) if (host_req[h] && gnt_seen[h]) host_req[h] = 1'b0;
  endtask

  task automatic set_req(input int h, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    host_req[h]   = 1'b1;
    host_addr[h]  = a;
    host_we[h]    = we;
    host_be[h]    = be;
    host_wdata[h] = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h0010_0000 | (32'($urandom) & 32'h000F_FFFC);
      1:       return 32'h0002_0000 | (32'($urandom) & 32'h0000_03FC);
      2:       return 32'h0003_0000 | (32'($urandom) & 32'h0000_03FC);
      3:       return 32'($urandom) & 32'h0000_FFFC;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int d = 0; d < ND; d++) err_sel[d] = ($urandom_range(0, 3) == 0);
      for (int h = 0; h < NH; h++) begin
        if (!host_req[h] && $urandom_range(0, 1) == 1)
          set_req(h, rand_addr(), 1'($urandom), 4'($urandom), 32'($urandom));
      end
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_ni   = 1'b0;
    for (int h = 0; h < NH; h++) begin
      host_req[h] = 1'b0; host_addr[h] = '0; host_we[h] = 1'b0;
      host_be[h] = '0; host_wdata[h] = '0; gnt_seen[h] = 1'b0;
    end
    for (int d = 0; d < ND; d++) err_sel[d] = 1'b0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;

    // Request held during reset must stay ungranted; becomes the first RAM read.
    set_req(0, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b1;

    step();
    set_req(0, 32'h0002_0008, 1'b1, 4'b0001, 32'h41);
    step();
    set_req(0, 32'h0003_0000, 1'b0, 4'hF, 32'h0);
    err_sel[2] = 1'b1;
    step();
    err_sel[2] = 1'b0;
    set_req(0, 32'h0000_0004, 1'b0, 4'hF, 32'h0);
    step();
    set_req(0, 32'h0010_0100, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'h0002_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    step();
    step();
    step();

    random_cycles(250);

    // Reset while a response is pending: it must be dropped.
    if (!host_req[0]) set_req(0, 32'h0010_0200, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b1;

    random_cycles(250);

    // Overlapping windows: window 1 covers everything, RAM must still win its range.
    step();
    cfg_base[1] = 32'h0;
    cfg_mask[1] = 32'h0;
    random_cycles(80);

    step();
    for (int h = 0; h < NH; h++) host_req[h] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
